// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package md_pkg;

    // Operand width; one multiply/divide iteration is performed per operand bit.
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/operand/result bundle between the control FSM and the mult/div unit.
interface mult_div_unit_if #(
    parameter int WIDTH = md_pkg::MD_ITER
);
    logic             md_start;
    logic             md_op;
    logic [WIDTH-1:0] regA_out;
    logic [WIDTH-1:0] regB_out;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             md_busy;
    logic             md_done;
    logic             div_zero;

    modport master (
        output md_start, md_op, regA_out, regB_out,
        input  hi_out, lo_out, md_busy, md_done, div_zero
    );

    modport slave (
        input  md_start, md_op, regA_out, regB_out,
        output hi_out, lo_out, md_busy, md_done, div_zero
    );
endinterface

// File: rtl/md_sign_fix.sv
// Final sign correction: MULT passes through, DIV negates quotient on differing
// operand signs and gives the remainder the dividend's sign.
module md_sign_fix
    import md_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);
    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (op == MD_OP_DIV) begin
            if (sign_a ^ sign_b) fix_lo = -raw_lo;
            if (sign_a)          fix_hi = -raw_hi;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) producing HI/LO.
//   state   | meaning
//   MD_IDLE | waiting for md_start; results held
//   MD_RUN  | one Booth step or quotient bit per clock
//   MD_FIX  | sign-correct and write HI/LO, pulse md_done
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);
    localparam int CW = $clog2(WIDTH);

    md_state_t        state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [2*WIDTH:0] acc_q;
    logic [WIDTH-1:0] opnd_q, hi_q, lo_q;
    logic             op_q, sign_a_q, sign_b_q, zero_q, done_q, dz_q;
    logic             accept;

    logic [WIDTH-1:0] a_mag, b_mag, raw_hi, raw_lo, fix_hi, fix_lo;
    logic [WIDTH:0]   booth_hi, booth_opnd, booth_sum, div_shift, div_diff;
    logic [2*WIDTH:0] iter_next;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                // A start coinciding with the done pulse is still dropped.
                if (md.md_start && !done_q) begin
                    accept  = 1'b1;
                    state_d = (md.md_op == MD_OP_DIV && md.regB_out == '0) ? MD_FIX : MD_RUN;
                end
            end
            MD_RUN:  if (count_q == CW'(WIDTH - 1)) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    assign a_mag = md.regA_out[WIDTH-1] ? -md.regA_out : md.regA_out;
    assign b_mag = md.regB_out[WIDTH-1] ? -md.regB_out : md.regB_out;

    // Booth add is one bit wider so a most-negative multiplicand cannot overflow.
    always_comb begin
        booth_hi   = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        booth_opnd = {opnd_q[WIDTH-1], opnd_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_hi + booth_opnd;
            2'b10:   booth_sum = booth_hi - booth_opnd;
            default: booth_sum = booth_hi;
        endcase
    end

    // Divide reuses the accumulator: remainder above, dividend/quotient below.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_comb begin
        if (op_q == MD_OP_MULT)
            iter_next = {booth_sum, acc_q[WIDTH:1]};
        else if (!div_diff[WIDTH])
            iter_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        else
            iter_next = {div_shift, acc_q[WIDTH-2:0], 1'b0};
    end

    assign raw_hi = (op_q == MD_OP_MULT) ? acc_q[2*WIDTH:WIDTH+1] : acc_q[2*WIDTH-1:WIDTH];
    assign raw_lo = (op_q == MD_OP_MULT) ? acc_q[WIDTH:1]         : acc_q[WIDTH-1:0];

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op     (op_q),
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .raw_hi (raw_hi),
        .raw_lo (raw_lo),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        op_q     <= md.md_op;
                        sign_a_q <= md.regA_out[WIDTH-1];
                        sign_b_q <= md.regB_out[WIDTH-1];
                        zero_q   <= (md.md_op == MD_OP_DIV) && (md.regB_out == '0);
                        dz_q     <= 1'b0;
                        count_q  <= '0;
                        if (md.md_op == MD_OP_MULT) begin
                            acc_q  <= {{WIDTH{1'b0}}, md.regB_out, 1'b0};
                            opnd_q <= md.regA_out;
                        end else begin
                            acc_q  <= {{(WIDTH+1){1'b0}}, a_mag};
                            opnd_q <= b_mag;
                        end
                    end
                end
                MD_RUN: begin
                    acc_q   <= iter_next;
                    count_q <= count_q + CW'(1);
                end
                MD_FIX: begin
                    done_q <= 1'b1;
                    dz_q   <= zero_q;
                    if (!zero_q) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.hi_out   = hi_q;
    assign md.lo_out   = lo_q;
    assign md.md_done  = done_q;
    assign md.div_zero = dz_q;
    assign md.md_busy  = (state_q != MD_IDLE) || done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random MULT/DIV
// against a plain-arithmetic reference model.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dz;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, truncating division, unchanged HI/LO on /0.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            p = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
        end else if (b == 32'd0) begin
            exp_dz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_dz = 1'b0;
        end
    endtask

    // lat = clock edges elapsed since the start edge; disturb/abort < 0 means none.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int disturb, input int abort_at);
        int lat;
        int exp_lat;
        bit busy_ok;
        exp_lat = (op && b == 32'd0) ? 1 : 33;
        @(negedge clk);
        bus.md_start = 1'b1;
        bus.md_op    = op;
        bus.regA_out = a;
        bus.regB_out = b;
        @(negedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            bus.md_start = (lat == disturb);
            bus.md_op    = ~op;
            bus.regA_out = $urandom;
            bus.regB_out = $urandom;
            if (lat == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_hi",   bus.hi_out,   0);
                chk("abort_lo",   bus.lo_out,   0);
                chk("abort_busy", bus.md_busy,  0);
                chk("abort_done", bus.md_done,  0);
                chk("abort_dz",   bus.div_zero, 0);
                @(negedge clk);
                bus.md_start = 1'b0;
                reset  = 1'b1;
                exp_hi = '0;
                exp_lo = '0;
                exp_dz = 1'b0;
                return;
            end
            if (!bus.md_busy) busy_ok = 1'b0;
            if (bus.md_done) break;
            @(negedge clk);
            lat++;
        end
        model(op, a, b);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy",    64'(busy_ok), 1);
        chk("hi",      bus.hi_out,   exp_hi);
        chk("lo",      bus.lo_out,   exp_lo);
        chk("div_zero", bus.div_zero, exp_dz);
        @(negedge clk);
        bus.md_start = 1'b0;
        chk("done_pulse", bus.md_done, 0);
        chk("idle_busy",  bus.md_busy, 0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'($signed($urandom_range(0, 40)) - 20);
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        op;
        logic [31:0] a, b;
        int          d;
        n_checks = 0;
        n_errors = 0;
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        reset = 1'b0;
        bus.md_start = 1'b0;
        bus.md_op    = 1'b0;
        bus.regA_out = '0;
        bus.regB_out = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi",   bus.hi_out,   0);
        chk("rst_lo",   bus.lo_out,   0);
        chk("rst_busy", bus.md_busy,  0);
        chk("rst_done", bus.md_done,  0);
        chk("rst_dz",   bus.div_zero, 0);
        reset = 1'b1;

        do_op(1'b0, 32'd7, 32'd6, -1, -1);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1);
        do_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        do_op(1'b0, 32'h0001_2345, 32'h0000_6789, -1, -1);
        do_op(1'b1, 32'd5, 32'd0, -1, -1);
        do_op(1'b0, 32'hFFFF_FFFD, 32'd11, -1, -1);
        do_op(1'b0, 32'd3, 32'd3, 10, -1);
        do_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 33, -1);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);

        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = rand_opnd();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_opnd();
            d  = $urandom_range(1, 40);
            do_op(op, a, b, d, -1);
        end

        do_op(1'b0, 32'd123, 32'd45, -1, -1);
        do_op(1'b1, 32'd100, 32'd7, -1, 15);
        chk("post_rst_lo", bus.lo_out, 0);
        do_op(1'b1, 32'd100, 32'd7, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
